rf_op_seq: RTL and testbench

Single-issue operation sequencer that drives the 4-entry × 1-bit register file (two read ports, one write port). Each accepted command reads up to two registers, applies a 1-bit logic operation, and writes the result back. Load-immediate commands write a bit directly. The block sits directly upstream of the register file: it generates all of the file's read/write addresses and its write strobe, and it consumes the file's two read outputs.

---
 rtl/rf_op_seq.sv | 135 +++++++++++++
 tb/tb_rf_op_seq.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_op_seq.sv
// Single-issue sequencer for a 4x1-bit register file: reads up to two
// operands, applies AND/OR/XOR (or load-immediate) and writes the bit back.
module rf_op_seq #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [1:0]       cmd_src1,
  input  logic [1:0]       cmd_src2,
  input  logic [1:0]       cmd_dst,
  input  logic             cmd_imm,
  output logic [1:0]       rf_upr_1,
  output logic [1:0]       rf_upr_2,
  input  logic             rf_out_1,
  input  logic             rf_out_2,
  output logic [1:0]       rf_upr_in,
  output logic             rf_data,
  output logic             rf_WE,
  output logic             done,
  output logic             result,
  output logic [CNT_W-1:0] op_cnt
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

  localparam logic [1:0] OpAnd = 2'b00;
  localparam logic [1:0] OpOr  = 2'b01;
  localparam logic [1:0] OpXor = 2'b10;
  localparam logic [1:0] OpLdi = 2'b11;

  state_e           r_state, w_state_d;
  logic [1:0]       r_op, r_dst;
  logic             r_a, r_b;
  logic [1:0]       r_upr_1, r_upr_2, r_upr_in;
  logic             r_data, r_we, r_done, r_result;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept;
  logic             w_alu;

  assign cmd_ready = (r_state == StIdle) && rst_n;
  assign w_accept  = cmd_valid && cmd_ready;

  // Evaluated on the live read data so the write bit is registered when
  // WRITE begins; it equals op(A, B) since A/B capture the same values.
  always_comb begin
    w_alu = 1'b0;
    unique case (r_op)
      OpAnd:   w_alu = rf_out_1 & rf_out_2;
      OpOr:    w_alu = rf_out_1 | rf_out_2;
      OpXor:   w_alu = rf_out_1 ^ rf_out_2;
      default: w_alu = 1'b0;
    endcase
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_d = (cmd_op == OpLdi) ? StWrite : StRead;
      StRead:  w_state_d = StWrite;
      StWrite: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op     <= 2'b00;
      r_dst    <= 2'b00;
      r_a      <= 1'b0;
      r_b      <= 1'b0;
      r_upr_1  <= 2'b00;
      r_upr_2  <= 2'b00;
      r_upr_in <= 2'b00;
      r_data   <= 1'b0;
      r_we     <= 1'b0;
      r_done   <= 1'b0;
      r_result <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_op  <= cmd_op;
            r_dst <= cmd_dst;
            if (cmd_op == OpLdi) begin
              r_we     <= 1'b1;
              r_upr_in <= cmd_dst;
              r_data   <= cmd_imm;
            end else begin
              r_upr_1 <= cmd_src1;
              r_upr_2 <= cmd_src2;
            end
          end
        end
        StRead: begin
          r_a      <= rf_out_1;
          r_b      <= rf_out_2;
          r_we     <= 1'b1;
          r_upr_in <= r_dst;
          r_data   <= w_alu;
        end
        StWrite: begin
          r_result <= r_data;
          r_cnt    <= r_cnt + CNT_W'(1);
          r_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rf_upr_1  = r_upr_1;
  assign rf_upr_2  = r_upr_2;
  assign rf_upr_in = r_upr_in;
  assign rf_data   = r_data;
  assign rf_WE     = r_we;
  assign done      = r_done;
  assign result    = r_result;
  assign op_cnt    = r_cnt;

  // Operand copies are kept for observability; the write bit already folds them in.
  logic w_unused_ops;
  assign w_unused_ops = r_a ^ r_b;

endmodule

// File: tb/tb_rf_op_seq.sv
// Bench for rf_op_seq: hosts a 4x1-bit register file and checks each command
// against a bit-level model of the file, the counter and the result.
module tb_rf_op_seq;
  localparam int CNT_W = 4;
  localparam int CNT_MOD = 1 << CNT_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic [1:0]       cmd_op = '0, cmd_src1 = '0, cmd_src2 = '0, cmd_dst = '0;
  logic             cmd_imm = 1'b0;
  logic             cmd_ready;
  logic [1:0]       rf_upr_1, rf_upr_2, rf_upr_in;
  logic             rf_out_1, rf_out_2, rf_data, rf_WE, done, result;
  logic [CNT_W-1:0] op_cnt;

  logic rf_mem [4];
  assign rf_out_1 = rf_mem[rf_upr_1];
  assign rf_out_2 = rf_mem[rf_upr_2];
  always @(posedge clk) if (rf_WE) rf_mem[rf_upr_in] <= rf_data;

  always #5 clk = ~clk;

  rf_op_seq #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_src1(cmd_src1), .cmd_src2(cmd_src2), .cmd_dst(cmd_dst),
    .cmd_imm(cmd_imm), .rf_upr_1(rf_upr_1), .rf_upr_2(rf_upr_2), .rf_out_1(rf_out_1),
    .rf_out_2(rf_out_2), .rf_upr_in(rf_upr_in), .rf_data(rf_data), .rf_WE(rf_WE),
    .done(done), .result(result), .op_cnt(op_cnt)
  );

  int   checks = 0;
  int   errors = 0;
  logic m_rf [4];
  int   m_cnt = 0;

  function automatic logic ref_op(input logic [1:0] op, input logic a, input logic b,
                                  input logic imm);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return imm;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge following acceptance.
  task automatic issue(input logic [1:0] op, input logic [1:0] s1, input logic [1:0] s2,
                       input logic [1:0] d, input logic imm);
    int n = 0;
    cmd_op = op; cmd_src1 = s1; cmd_src2 = s2; cmd_dst = d; cmd_imm = imm;
    cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout: cmd_ready=%b required 1", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b0 || rf_WE !== 1'b0 || op_cnt !== '0 || result !== 1'b0) begin
        errors++;
        $display("FAIL reset_state: ready=%b we=%b cnt=%0d result=%b required 0 0 0 0",
                 cmd_ready, rf_WE, op_cnt, result);
      end
    end
    cmd_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: cmd_ready=%b required 1", cmd_ready);
    end
    m_cnt = 0;
  endtask

  task automatic test_ldi_fill();
    logic [3:0] vals = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      issue(2'b11, 2'd0, 2'd0, 2'(i), vals[i]);
      m_rf[i] = vals[i];
      m_cnt = (m_cnt + 1) % CNT_MOD;
      checks++;
      if (rf_WE !== 1'b1 || rf_upr_in !== 2'(i) || rf_data !== vals[i] || done !== 1'b0) begin
        errors++;
        $display("FAIL ldi_write r%0d: we=%b addr=%0d data=%b done=%b required 1 %0d %b 0",
                 i, rf_WE, rf_upr_in, rf_data, done, i, vals[i]);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || result !== vals[i] || op_cnt !== CNT_W'(m_cnt) ||
          rf_mem[i] !== m_rf[i] || rf_WE !== 1'b0) begin
        errors++;
        $display("FAIL ldi_done r%0d: done=%b result=%b cnt=%0d rf=%b we=%b required 1 %b %0d %b 0",
                 i, done, result, op_cnt, rf_mem[i], rf_WE, vals[i], m_cnt, m_rf[i]);
      end
    end
  endtask

  task automatic test_logic_ops();
    // {op, src1, src2, dst}: AND r0,r2->r1; XOR r0,r2->r3; OR r1,r3->r0
    logic [7:0] tbl [3] = '{8'b00_00_10_01, 8'b10_00_10_11, 8'b01_01_11_00};
    logic [2:0] want = 3'b101;
    for (int i = 0; i < 3; i++) begin
      logic [1:0] op, s1, s2, d;
      logic       exp;
      {op, s1, s2, d} = tbl[i];
      exp = ref_op(op, m_rf[s1], m_rf[s2], 1'b0);
      checks++;
      if (exp !== want[i]) begin
        errors++;
        $display("FAIL logic_model_%0d: model=%b required %b", i, exp, want[i]);
      end
      issue(op, s1, s2, d, 1'b0);
      checks++;
      if (rf_upr_1 !== s1 || rf_upr_2 !== s2 || rf_WE !== 1'b0 || cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL logic_read_%0d: a1=%0d a2=%0d we=%b rdy=%b required %0d %0d 0 0",
                 i, rf_upr_1, rf_upr_2, rf_WE, cmd_ready, s1, s2);
      end
      @(negedge clk);
      checks++;
      if (rf_WE !== 1'b1 || rf_upr_in !== d || rf_data !== exp) begin
        errors++;
        $display("FAIL logic_write_%0d: we=%b addr=%0d data=%b required 1 %0d %b",
                 i, rf_WE, rf_upr_in, rf_data, d, exp);
      end
      m_rf[d] = exp;
      m_cnt = (m_cnt + 1) % CNT_MOD;
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || result !== exp || op_cnt !== CNT_W'(m_cnt) || rf_mem[d] !== exp) begin
        errors++;
        $display("FAIL logic_done_%0d: done=%b result=%b cnt=%0d rf=%b required 1 %b %0d %b",
                 i, done, result, op_cnt, rf_mem[d], exp, m_cnt, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic e1, e2;
    e1 = ref_op(2'b10, m_rf[3], m_rf[3], 1'b0);
    cmd_op = 2'b10; cmd_src1 = 2'd3; cmd_src2 = 2'd3; cmd_dst = 2'd3; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_op = 2'b00; cmd_src1 = 2'd3; cmd_src2 = 2'd0; cmd_dst = 2'd2;
    checks++;
    if (cmd_ready !== 1'b0 || rf_upr_1 !== 2'd3 || rf_upr_2 !== 2'd3) begin
      errors++;
      $display("FAIL b2b_read1: rdy=%b a1=%0d a2=%0d required 0 3 3", cmd_ready, rf_upr_1, rf_upr_2);
    end
    @(negedge clk);
    m_rf[3] = e1;
    m_cnt = (m_cnt + 1) % CNT_MOD;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || cmd_ready !== 1'b1 || rf_mem[3] !== 1'b0 || result !== e1) begin
      errors++;
      $display("FAIL b2b_done1: done=%b rdy=%b r3=%b result=%b required 1 1 0 %b",
               done, cmd_ready, rf_mem[3], result, e1);
    end
    e2 = ref_op(2'b00, m_rf[3], m_rf[0], 1'b0);
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (rf_upr_1 !== 2'd3 || rf_upr_2 !== 2'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_read2: a1=%0d a2=%0d done=%b required 3 0 0", rf_upr_1, rf_upr_2, done);
    end
    @(negedge clk);
    checks++;
    if (rf_WE !== 1'b1 || rf_upr_in !== 2'd2 || rf_data !== e2) begin
      errors++;
      $display("FAIL b2b_write2: we=%b addr=%0d data=%b required 1 2 %b", rf_WE, rf_upr_in,
               rf_data, e2);
    end
    m_rf[2] = e2;
    m_cnt = (m_cnt + 1) % CNT_MOD;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || rf_mem[2] !== 1'b0 || op_cnt !== CNT_W'(m_cnt)) begin
      errors++;
      $display("FAIL b2b_done2: done=%b r2=%b cnt=%0d required 1 0 %0d", done, rf_mem[2], op_cnt,
               m_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      logic [1:0] op, s1, s2, d;
      logic       imm, exp;
      op = 2'($urandom_range(3)); s1 = 2'($urandom_range(3));
      s2 = 2'($urandom_range(3)); d = 2'($urandom_range(3)); imm = 1'($urandom_range(1));
      exp = ref_op(op, m_rf[s1], m_rf[s2], imm);
      issue(op, s1, s2, d, imm);
      if (op != 2'b11) begin
        checks++;
        if (rf_upr_1 !== s1 || rf_upr_2 !== s2 || rf_WE !== 1'b0) begin
          errors++;
          $display("FAIL rnd_read_%0d: a1=%0d a2=%0d we=%b required %0d %0d 0", i, rf_upr_1,
                   rf_upr_2, rf_WE, s1, s2);
        end
        @(negedge clk);
      end
      checks++;
      if (rf_WE !== 1'b1 || rf_upr_in !== d || rf_data !== exp) begin
        errors++;
        $display("FAIL rnd_write_%0d: op=%0d we=%b addr=%0d data=%b required 1 %0d %b", i, op,
                 rf_WE, rf_upr_in, rf_data, d, exp);
      end
      m_rf[d] = exp;
      m_cnt = (m_cnt + 1) % CNT_MOD;
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || result !== exp || op_cnt !== CNT_W'(m_cnt) || rf_mem[d] !== exp) begin
        errors++;
        $display("FAIL rnd_done_%0d: done=%b result=%b cnt=%0d rf=%b required 1 %b %0d %b", i,
                 done, result, op_cnt, rf_mem[d], exp, m_cnt, exp);
      end
      repeat ($urandom_range(1)) @(negedge clk);
    end
  endtask

  task automatic test_mid_op_reset();
    logic keep;
    keep = m_rf[2];
    issue(2'b10, 2'd0, 2'd1, 2'd2, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (rf_WE !== 1'b0 || done !== 1'b0 || op_cnt !== '0 || cmd_ready !== 1'b0 ||
        result !== 1'b0) begin
      errors++;
      $display("FAIL midrst_in_reset: we=%b done=%b cnt=%0d rdy=%b result=%b required 0 0 0 0 0",
               rf_WE, done, op_cnt, cmd_ready, result);
    end
    rst_n = 1'b1;
    m_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (rf_WE !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1 || op_cnt !== '0) begin
        errors++;
        $display("FAIL midrst_after_%0d: we=%b done=%b rdy=%b cnt=%0d required 0 0 1 0", i,
                 rf_WE, done, cmd_ready, op_cnt);
      end
    end
    checks++;
    if (rf_mem[2] !== keep) begin
      errors++;
      $display("FAIL midrst_no_write: r2=%b required %b", rf_mem[2], keep);
    end
  endtask

  task automatic test_counter_wrap();
    for (int i = 0; i < 16; i++) begin
      logic imm;
      imm = 1'($urandom_range(1));
      issue(2'b11, 2'd0, 2'd0, 2'(i % 4), imm);
      m_rf[i % 4] = imm;
      m_cnt = (m_cnt + 1) % CNT_MOD;
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || op_cnt !== CNT_W'(m_cnt) || result !== imm) begin
        errors++;
        $display("FAIL wrap_%0d: done=%b cnt=%0d result=%b required 1 %0d %b", i, done, op_cnt,
                 result, m_cnt, imm);
      end
    end
    checks++;
    if (op_cnt !== '0) begin
      errors++;
      $display("FAIL wrap_final: cnt=%0d required 0", op_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_ldi_fill();
    test_logic_ops();
    test_back_to_back();
    test_random();
    test_mid_op_reset();
    test_counter_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
